// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style datapath slice: widths, ALU opcodes,
// register count and the operand-stage occupancy state type.
package mips_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 2;
    localparam int IMM_W    = 8;
    localparam int OP_W     = 4;
    localparam int NUM_REGS = 1 << ADDR_W;

    localparam logic [OP_W-1:0] OP_AND  = 4'b0000;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b0010;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0110;
    localparam logic [OP_W-1:0] OP_SLT  = 4'b0111;
    localparam logic [OP_W-1:0] OP_NOR  = 4'b1100;
    localparam logic [OP_W-1:0] OP_NAND = 4'b1101;

    // Occupancy of the single output slot feeding the ALU.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

endpackage

// File: rtl/operand_stage_reg_file.sv
// Architectural register file: 2^ADDR_W entries, r0 reads as zero,
// two combinational read ports with write-through bypass from the WB port.
module reg_file #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic              wb_live;

    // Writes to r0 are dropped so it stays zero forever.
    assign wb_live = wb_en && (wb_addr != '0);

    // Synchronous write port; reset clears every entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_live) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Read ports: r0 forced to zero, otherwise same-cycle write wins over storage.
    always_comb begin
        ra_data = regs[ra_addr];
        if (ra_addr == '0) begin
            ra_data = '0;
        end else if (wb_live && (wb_addr == ra_addr)) begin
            ra_data = wb_data;
        end

        rb_data = regs[rb_addr];
        if (rb_addr == '0) begin
            rb_data = '0;
        end else if (wb_live && (wb_addr == rb_addr)) begin
            rb_data = wb_data;
        end
    end

endmodule

// File: rtl/operand_stage.sv
// ID/EX operand stage: reads rs/rt from the register file, builds operand b
// from rt or the extended immediate, and holds op/a/b/rd in a registered
// valid/ready slot with stall, hold-time write-back refresh and flush.
// Build option: OPERAND_STAGE_ZEXT_LOGIC_EN zero-extends the immediate for
// the logical ops (AND, OR, NOR, NAND); otherwise it is always sign-extended.
module operand_stage #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int IMM_W  = mips_pkg::IMM_W,
    parameter int OP_W   = mips_pkg::OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_use_imm,
    input  logic              in_reg_write,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_reg_write
);

    import mips_pkg::*;

    stage_state_t             state;
    logic [DATA_W-1:0]        rs_val;
    logic [DATA_W-1:0]        rt_val;
    logic signed [DATA_W-1:0] b_sel;
    logic                     accept;
    logic                     wb_live;

    logic [OP_W-1:0]          op_p1;
    logic signed [DATA_W-1:0] a_p1;
    logic signed [DATA_W-1:0] b_p1;
    logic [ADDR_W-1:0]        rd_p1;
    logic [ADDR_W-1:0]        rs_p1;
    logic [ADDR_W-1:0]        rt_p1;
    logic                     rw_p1;
    logic                     use_imm_p1;

`ifdef OPERAND_STAGE_ZEXT_LOGIC_EN
    function automatic logic signed [DATA_W-1:0] ext_imm(
        input logic [IMM_W-1:0] imm,
        input logic [OP_W-1:0]  op
    );
        if (op == OP_AND || op == OP_OR || op == OP_NOR || op == OP_NAND) begin
            return {{(DATA_W-IMM_W){1'b0}}, imm};
        end
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction
`else
    function automatic logic signed [DATA_W-1:0] ext_imm(
        input logic [IMM_W-1:0] imm
    );
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction
`endif

    reg_file #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_reg_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .ra_addr (in_rs),
        .ra_data (rs_val),
        .rb_addr (in_rt),
        .rb_data (rt_val)
    );

    assign wb_live = wb_en && (wb_addr != '0);

    // Flush blocks intake for its cycle; otherwise the slot takes a new
    // instruction whenever it is empty or being drained.
    assign in_ready = !flush && ((state == ST_EMPTY) || out_ready);
    assign accept   = in_valid && in_ready;

    // Operand b source select.
    always_comb begin
`ifdef OPERAND_STAGE_ZEXT_LOGIC_EN
        b_sel = in_use_imm ? ext_imm(in_imm, in_op) : $signed(rt_val);
`else
        b_sel = in_use_imm ? ext_imm(in_imm) : $signed(rt_val);
`endif
    end

    // ---- p0 (decode/read) -> p1 (registered ALU operands) ----
    // Slot FSM and output registers: flush > accept > drain > hold refresh.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            op_p1      <= '0;
            a_p1       <= '0;
            b_p1       <= '0;
            rd_p1      <= '0;
            rs_p1      <= '0;
            rt_p1      <= '0;
            rw_p1      <= 1'b0;
            use_imm_p1 <= 1'b0;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else if (accept) begin
            state      <= ST_FULL;
            op_p1      <= in_op;
            a_p1       <= $signed(rs_val);
            b_p1       <= b_sel;
            rd_p1      <= in_rd;
            rs_p1      <= in_rs;
            rt_p1      <= in_rt;
            rw_p1      <= in_reg_write;
            use_imm_p1 <= in_use_imm;
        end else if (state == ST_FULL && out_ready) begin
            state <= ST_EMPTY;
        end else if (state == ST_FULL) begin
            // Stalled: keep held operands coherent with late write-backs.
            if (wb_live && (wb_addr == rs_p1)) begin
                a_p1 <= $signed(wb_data);
            end
            if (wb_live && (wb_addr == rt_p1) && !use_imm_p1) begin
                b_p1 <= $signed(wb_data);
            end
        end
    end

    assign out_valid     = (state == ST_FULL);
    assign out_op        = op_p1;
    assign out_a         = a_p1;
    assign out_b         = b_p1;
    assign out_rd        = rd_p1;
    assign out_reg_write = rw_p1;

endmodule
